// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, access-type encodings, FSM state encoding and
// small helpers for the byte-wide memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  // Access size encodings carried on lsb_d_type_in.
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_B    = 2'b01;
  localparam logic [1:0] MEM_H    = 2'b10;
  localparam logic [1:0] MEM_W    = 2'b11;

  // Address bits [17:16] == 2'b11 select the IO region (UART behind a buffer).
  localparam int         IO_SEL_HI = 17;
  localparam int         IO_SEL_LO = 16;
  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_LSB = 1'b0,
    OWN_IF  = 1'b1
  } owner_e;

  // One load/store request as presented by the LSB.
  typedef struct packed {
    logic                  rw;
    logic [1:0]            d_type;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } lsb_req_t;

  // Number of byte transfers for an access size.
  function automatic logic [2:0] byte_count(input logic [1:0] d_type);
    logic [2:0] n;
    case (d_type)
      MEM_B:   n = 3'd1;
      MEM_H:   n = 3'd2;
      MEM_W:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // True when the address falls in the IO region.
  function automatic logic is_io(input logic [ADDR_WIDTH-1:0] addr);
    return addr[IO_SEL_HI:IO_SEL_LO] == IO_REGION;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serves LSB loads/stores and instruction fetches over a byte-wide
// RAM/IO bus. Each access is split into byte transfers at base+k; load bytes
// are reassembled little-endian and returned with a one-cycle pulse.
//
// Handshake: a request from the LSB is a nonzero lsb_d_type_in held for exactly
// one cycle (with rw/addr/data valid in that cycle); it is always accepted,
// either started directly from IDLE or parked in a one-entry pending latch.
// Completion is a registered one-cycle pulse (lsb_din_en_out for loads with
// lsb_din_out valid, lsb_w_done_out for stores). Instruction fetch holds
// if_en_in as a level until it sees the one-cycle if_done_out pulse with
// if_data_out valid; if_en_in is ignored in the pulse cycle itself.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  roll_back,
  input  logic                  lsb_rw_in,
  input  logic [1:0]            lsb_d_type_in,
  input  logic [ADDR_WIDTH-1:0] lsb_addr_in,
  input  logic [DATA_WIDTH-1:0] lsb_data_in,
  output logic                  lsb_din_en_out,
  output logic [DATA_WIDTH-1:0] lsb_din_out,
  output logic                  lsb_w_done_out,
  input  logic                  if_en_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_done_out,
  output logic [DATA_WIDTH-1:0] if_data_out,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  output logic [1:0]            dbg_state
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [2:0]            n_q;
  logic [2:0]            k_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  owner_e                owner_q;
  logic                  pend_valid_q;
  lsb_req_t              pend_q;

  logic                  din_en_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  w_done_q;
  logic                  if_done_q;
  logic [DATA_WIDTH-1:0] if_data_q;

  lsb_req_t              cur_req;
  lsb_req_t              lsb_sel;
  logic                  new_req;
  logic                  idle;
  logic                  lsb_avail;
  logic                  start_lsb;
  logic                  start_if;
  logic                  io_stall;
  logic                  rd_last;
  logic                  wr_fire;
  logic                  wr_last;
  logic [2:0]            cap_idx;
  logic [2:0]            rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            wr_byte;

  assign cur_req   = {lsb_rw_in, lsb_d_type_in, lsb_addr_in, lsb_data_in};
  assign new_req   = (lsb_d_type_in != MEM_NONE);
  assign idle      = (state_q == ST_IDLE);
  // A parked request always wins over a new pulse; both cannot coexist.
  assign lsb_sel   = pend_valid_q ? pend_q : cur_req;
  assign lsb_avail = pend_valid_q | new_req;
  // Rollback drops loads but never stores.
  assign start_lsb = rdy_in & idle & lsb_avail & ~(roll_back & ~lsb_sel.rw);
  assign start_if  = rdy_in & idle & ~lsb_avail & if_en_in & ~if_done_q & ~roll_back;

  assign io_stall  = (state_q == ST_WRITE) & is_io(base_q) & io_buffer_full;
  assign rd_last   = (state_q == ST_READ) & (k_q == n_q);
  assign wr_fire   = (state_q == ST_WRITE) & rdy_in & ~io_stall;
  assign wr_last   = wr_fire & (k_q == (n_q - 3'd1));
  // In READ, mem_din carries the byte addressed one cycle earlier, i.e. k-1.
  assign cap_idx   = k_q - 3'd1;
  assign wr_byte   = wdata_q[{k_q[1:0], 3'b000} +: 8];

  // Read address index: the next byte normally; while frozen (or after the last
  // address) keep presenting the first uncaptured byte so mem_din is valid for
  // it on the first cycle after resuming.
  always_comb begin
    rd_idx = k_q;
    if (!rdy_in || (k_q == n_q)) begin
      rd_idx = (k_q == 3'd0) ? 3'd0 : cap_idx;
    end
  end

  // Merge the byte currently on mem_din into its lane of the assembly register.
  always_comb begin
    rd_word = asm_q;
    for (int i = 0; i < 4; i++) begin
      if ((k_q != 3'd0) && (cap_idx == 3'(i))) begin
        rd_word[8*i +: 8] = mem_din;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; everything holds while rdy_in is low.
  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          if (start_lsb) begin
            state_d = lsb_sel.rw ? ST_WRITE : ST_READ;
          end else if (start_if) begin
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          if (roll_back || rd_last) begin
            state_d = ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (wr_last) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Bus outputs decoded from the current state and byte index.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (!rst_in) begin
      case (state_q)
        ST_READ: begin
          mem_a = base_q + {{(ADDR_WIDTH-3){1'b0}}, rd_idx};
        end
        ST_WRITE: begin
          mem_a    = base_q + {{(ADDR_WIDTH-3){1'b0}}, k_q};
          mem_dout = wr_byte;
          mem_wr   = rdy_in & ~io_stall;
        end
        default: begin
          mem_a = '0;
        end
      endcase
    end
  end

  // Access registers, pending latch, byte assembly and completion pulses.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      base_q       <= '0;
      n_q          <= '0;
      k_q          <= '0;
      asm_q        <= '0;
      wdata_q      <= '0;
      owner_q      <= OWN_LSB;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      din_en_q     <= 1'b0;
      din_q        <= '0;
      w_done_q     <= 1'b0;
      if_done_q    <= 1'b0;
      if_data_q    <= '0;
    end else begin
      din_en_q  <= 1'b0;
      w_done_q  <= 1'b0;
      if_done_q <= 1'b0;

      // Park a request that cannot start this cycle; drop parked loads on rollback.
      if (new_req && (!rdy_in || !idle) && !(rdy_in && roll_back && !lsb_rw_in)) begin
        pend_valid_q <= 1'b1;
        pend_q       <= cur_req;
      end else if (rdy_in && pend_valid_q && (start_lsb || (roll_back && !pend_q.rw))) begin
        pend_valid_q <= 1'b0;
      end

      if (rdy_in) begin
        if (start_lsb) begin
          base_q  <= lsb_sel.addr;
          n_q     <= byte_count(lsb_sel.d_type);
          k_q     <= 3'd0;
          wdata_q <= lsb_sel.data;
          asm_q   <= '0;
          owner_q <= OWN_LSB;
        end else if (start_if) begin
          base_q  <= if_addr_in;
          n_q     <= 3'd4;
          k_q     <= 3'd0;
          asm_q   <= '0;
          owner_q <= OWN_IF;
        end

        if ((state_q == ST_READ) && !roll_back) begin
          if (k_q != 3'd0) begin
            asm_q <= rd_word;
          end
          if (rd_last) begin
            if (owner_q == OWN_LSB) begin
              din_en_q <= 1'b1;
              din_q    <= rd_word;
            end else begin
              if_done_q <= 1'b1;
              if_data_q <= rd_word;
            end
          end else begin
            k_q <= k_q + 3'd1;
          end
        end

        if (wr_fire) begin
          k_q <= k_q + 3'd1;
          if (wr_last) begin
            w_done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign lsb_din_en_out = din_en_q;
  assign lsb_din_out    = din_q;
  assign lsb_w_done_out = w_done_q;
  assign if_done_out    = if_done_q;
  assign if_data_out    = if_data_q;
  assign dbg_state      = state_q;

endmodule
